seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
//  Shares one segment bus (a..g, dp) between NUM_DIGITS digits by sequencing digit enables.
//  Takes packed 4-bit hex nibbles from a producer counter or datapath through a valid/ready load.
//  Inserts blanking dead time between digits to avoid ghosting; sits between the logic and the pins.
// PARAMETERS
//  NUM_DIGITS      4     digits scanned (2..8)
//  ON_CYCLES       4000  clk cycles each digit is driven (>=1)
//  BLANK_CYCLES    16    clk cycles all digits are off between digits (>=1)
//  SEG_ACTIVE_LOW  1     1: seg_out/dp_out are inverted at the output
//  DIG_ACTIVE_LOW  1     1: dig_sel is inverted at the output
// PORTS
//  clk         in   1             system clock
//  rst         in   1             synchronous reset, active-high
//  wr_valid    in   1             new display value offered
//  wr_ready    out  1             controller can accept a value
//  wr_data     in   4*NUM_DIGITS  hex nibbles; nibble i = digit i (digit 0 = bits 3:0)
//  wr_dp       in   NUM_DIGITS    decimal point per digit
//  blank_mask  in   NUM_DIGITS    1 = digit i kept dark (sampled live, every DRIVE cycle)
//  seg_out     out  7             segments, bit0=a .. bit6=g
//  dp_out      out  1             decimal point segment
//  dig_sel     out  NUM_DIGITS    one-hot digit enable
//  frame_done  out  1             1-cycle pulse at the end of the last digit's DRIVE phase
// BEHAVIOUR
//  - All outputs registered. Reset: state=BLANK, idx=0, timer=0, display regs=0,
//    pending=0, wr_ready=1, frame_done=0, dig_sel/seg_out/dp_out all at their inactive level.
//  - FSM BLANK: dig_sel inactive, segments inactive; stays BLANK_CYCLES cycles, then enters DRIVE.
//    On BLANK->DRIVE with idx==0 and pending=1: the shadow value is copied to the display regs
//    and pending clears. This is the only point where displayed data changes (no tearing).
//  - FSM DRIVE: dig_sel[idx] active and seg_out = decode(nibble idx) for ON_CYCLES cycles,
//    then go to BLANK with idx = (idx==NUM_DIGITS-1) ? 0 : idx+1.
//    If idx==NUM_DIGITS-1, frame_done pulses on the DRIVE->BLANK cycle.
//  - blank_mask[idx]=1 during DRIVE: dig_sel and segments stay inactive; timing is unchanged.
//  - Timer: one counter, $clog2(max(ON,BLANK)+1) bits; cleared on every state change; no free-run.
//  - Load: accept when wr_valid && wr_ready. The shadow register latches wr_data/wr_dp and
//    pending=1, and wr_ready drops the next cycle. wr_ready returns to 1 the cycle after the
//    frame-boundary copy. A new wr_valid while pending is ignored (not latched).
//    A load and a copy in the same cycle: the copy uses the old shadow, and the new load
//    is not accepted (wr_ready=0).
//  - Decode, active-high before polarity (gfedcba hex):
//    0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//    dp_out = wr_dp bit of the digit.
//  - Polarity: final output = value ^ {SEG/DIG_ACTIVE_LOW}; the inactive level is 1 when active-low.
//  - Never more than one dig_sel bit active. A digit is never active in the cycle after a digit change.
//  - rst asserted mid-frame: next cycle equals the post-reset state; pending load discarded.
//  - Frame period = NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES) cycles exactly.
// TESTING (use ON_CYCLES=8, BLANK_CYCLES=2, NUM_DIGITS=4, active-low)
//  1 Reset: hold rst 3 cycles -> dig_sel=4'hF, seg_out=7'h7F, dp_out=1, wr_ready=1.
//    First dig_sel=4'hE appears 2 cycles after rst release.
//  2 Load wr_data=16'h3A10, wr_dp=4'b0100 -> digit0 seg_out=~7'h3F, digit1 ~7'h06,
//    digit2 ~7'h77 with dp_out=0, digit3 ~7'h4F. Each digit held 8 cycles; 2 blank cycles between.
//  3 Tear check: load 16'h1111, then load 16'h2222 mid-frame -> the second load is ignored
//    (wr_ready=0); all 4 digits show 1 for the whole frame; wr_ready=1 after the next frame start.
//  4 Frame timing: frame_done pulses every 40 cycles exactly; dig_sel is one-hot or all-off
//    on every cycle (assertion).
//  5 blank_mask=4'b0010 -> digit1 stays dark for its 8-cycle slot; other digits and the period
//    are unchanged.
//  6 Assert rst during digit2 DRIVE with a load pending -> outputs inactive next cycle;
//    the display regs read 0 on the next frame.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode 7-segment
//               display with blanking dead time and tear-free value loading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int ON_CYCLES      = 4000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic [NUM_DIGITS-1:0]     wr_dp,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_done
);

    localparam int c_MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int c_TMR_W   = $clog2(c_MAX_CYC + 1);
    localparam int c_IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [6:0]            c_SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  c_DP_XOR  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] c_DIG_XOR = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_TMR_W-1:0]      r_timer;
    logic [4*NUM_DIGITS-1:0] r_disp_data;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_pending;
    logic                    r_wr_ready;
    logic                    r_frame_done;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig;

    logic                    w_blank_done;
    logic                    w_drive_done;
    logic                    w_idx_last;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic                    w_copy;
    logic                    w_accept;
    logic [4*NUM_DIGITS-1:0] w_disp_data_nxt;
    logic [NUM_DIGITS-1:0]   w_disp_dp_nxt;
    logic                    w_drive_nxt;
    logic                    w_lit;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_mask_bit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_seg_dec;

    assign w_blank_done = (r_state == ST_BLANK) && (r_timer == c_TMR_W'(BLANK_CYCLES - 1));
    assign w_drive_done = (r_state == ST_DRIVE) && (r_timer == c_TMR_W'(ON_CYCLES - 1));
    assign w_idx_last   = (r_idx == c_IDX_W'(NUM_DIGITS - 1));
    assign w_idx_next   = w_idx_last ? '0 : r_idx + c_IDX_W'(1);

    // The shadow only reaches the display at the start of digit 0, so a frame never tears.
    assign w_copy          = w_blank_done && (r_idx == '0) && r_pending;
    assign w_accept        = wr_valid && r_wr_ready;
    assign w_disp_data_nxt = w_copy ? r_shadow_data : r_disp_data;
    assign w_disp_dp_nxt   = w_copy ? r_shadow_dp   : r_disp_dp;

    // Outputs are registered, so they are computed from the state being entered.
    assign w_drive_nxt = w_blank_done || ((r_state == ST_DRIVE) && !w_drive_done);
    assign w_lit       = w_drive_nxt && !w_mask_bit;

    always_comb begin
        w_nibble   = 4'h0;
        w_dp_bit   = 1'b0;
        w_mask_bit = 1'b0;
        w_onehot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nibble    = w_disp_data_nxt[i*4 +: 4];
                w_dp_bit    = w_disp_dp_nxt[i];
                w_mask_bit  = blank_mask[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_seg_dec = 7'h00;
        case (w_nibble)
            4'h0: w_seg_dec = 7'h3F;
            4'h1: w_seg_dec = 7'h06;
            4'h2: w_seg_dec = 7'h5B;
            4'h3: w_seg_dec = 7'h4F;
            4'h4: w_seg_dec = 7'h66;
            4'h5: w_seg_dec = 7'h6D;
            4'h6: w_seg_dec = 7'h7D;
            4'h7: w_seg_dec = 7'h07;
            4'h8: w_seg_dec = 7'h7F;
            4'h9: w_seg_dec = 7'h6F;
            4'hA: w_seg_dec = 7'h77;
            4'hB: w_seg_dec = 7'h7C;
            4'hC: w_seg_dec = 7'h39;
            4'hD: w_seg_dec = 7'h5E;
            4'hE: w_seg_dec = 7'h79;
            default: w_seg_dec = 7'h71;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_idx         <= '0;
            r_timer       <= '0;
            r_disp_data   <= '0;
            r_disp_dp     <= '0;
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_pending     <= 1'b0;
            r_wr_ready    <= 1'b1;
            r_frame_done  <= 1'b0;
            r_seg         <= c_SEG_XOR;
            r_dp          <= c_DP_XOR;
            r_dig         <= c_DIG_XOR;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (w_blank_done) begin
                        r_state <= ST_DRIVE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (w_drive_done) begin
                        r_state <= ST_BLANK;
                        r_timer <= '0;
                        r_idx   <= w_idx_next;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_timer <= '0;
                end
            endcase

            // A copy and an accept cannot coincide: accepting needs ready, which implies no pending.
            if (w_copy) begin
                r_disp_data <= r_shadow_data;
                r_disp_dp   <= r_shadow_dp;
                r_pending   <= 1'b0;
                r_wr_ready  <= 1'b1;
            end else if (w_accept) begin
                r_shadow_data <= wr_data;
                r_shadow_dp   <= wr_dp;
                r_pending     <= 1'b1;
                r_wr_ready    <= 1'b0;
            end

            r_frame_done <= w_drive_done && w_idx_last;
            r_seg        <= (w_lit ? w_seg_dec : 7'h00) ^ c_SEG_XOR;
            r_dp         <= (w_lit && w_dp_bit) ^ c_DP_XOR;
            r_dig        <= (w_lit ? w_onehot : {NUM_DIGITS{1'b0}}) ^ c_DIG_XOR;
        end
    end

    assign wr_ready   = r_wr_ready;
    assign frame_done = r_frame_done;
    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign dig_sel    = r_dig;

endmodule

`default_nettype wire
